fifo_writer_row: RTL and testbench

//  Write-side controller for one systolic-array row input FIFO, paired with the row read controller.
//  - Accepts a valid/ready operand stream.
//  - Writes exactly BATCH = ROW*COL words into the FIFO.
//  - Publishes the occupancy count the read controller waits on.
//  - Freezes writes until the reader has drained the FIFO to zero, then re-arms for the next batch.

---
 rtl/fifo_writer_row.sv | 105 ++++++++++
 tb/tb_fifo_writer_row.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_writer_row.sv
// Write-side controller for one systolic-array row input FIFO: accepts a
// valid/ready stream, writes one batch, then waits for the reader to drain it.
module fifo_writer_row #(
   parameter int ROW    = 9,
   parameter int COL    = 1,
   parameter int W_ADDR = 8,
   parameter int W_DATA = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [W_DATA-1:0] i_data,
   output logic              o_ready,
   output logic              o_fifo_wr_en,
   output logic [W_DATA-1:0] o_fifo_wr_data,
   input  logic              i_fifo_full,
   input  logic              i_fifo_rd_en,
   output logic [W_ADDR:0]   o_occupants,
   output logic              o_fifo_empty,
   output logic              o_batch_done,
   output logic              o_underflow
);

   localparam int              BATCH      = ROW * COL;
   localparam logic [W_ADDR:0] BatchCount = (W_ADDR+1)'(BATCH);
   localparam logic [W_ADDR:0] LastCount  = (W_ADDR+1)'(BATCH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [W_ADDR:0]   wrCnt_q, wrCnt_d;
   logic [W_ADDR:0]   occ_q, occ_d;
   logic              wrEn_q;
   logic [W_DATA-1:0] wrData_q;
   logic              batchDone_q, batchDone_d;
   logic              underflow_q;
   logic              accept;
   logic              rdCounted;

   assign o_ready   = (state_q == FILL) && !i_fifo_full && (wrCnt_q < BatchCount);
   assign accept    = i_valid && o_ready;
   assign rdCounted = i_fifo_rd_en && (occ_q != '0);

   // Drain completes only once the final registered write has landed in the count.
   always_comb begin
      state_d     = state_q;
      wrCnt_d     = wrCnt_q;
      batchDone_d = 1'b0;
      case (state_q)
         IDLE: begin
            wrCnt_d = '0;
            if (occ_q == '0) state_d = FILL;
         end
         FILL: begin
            if (accept) begin
               wrCnt_d = wrCnt_q + 1'b1;
               if (wrCnt_q == LastCount) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((occ_q == '0) && !wrEn_q) begin
               batchDone_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      if (wrEn_q && !rdCounted && (occ_q < BatchCount)) occ_d = occ_q + 1'b1;
      else if (rdCounted && !wrEn_q)                    occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         wrCnt_q     <= '0;
         occ_q       <= '0;
         wrEn_q      <= 1'b0;
         wrData_q    <= '0;
         batchDone_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrCnt_q     <= wrCnt_d;
         occ_q       <= occ_d;
         wrEn_q      <= accept;
         if (accept) wrData_q <= i_data;
         batchDone_q <= batchDone_d;
         underflow_q <= underflow_q || (i_fifo_rd_en && (occ_q == '0));
      end
   end

   assign o_fifo_wr_en   = wrEn_q;
   assign o_fifo_wr_data = wrData_q;
   assign o_occupants    = occ_q;
   assign o_fifo_empty   = (occ_q == '0);
   assign o_batch_done   = batchDone_q;
   assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_writer_row.sv
// Self-checking bench for fifo_writer_row: directed batch scenarios plus
// randomized batches, compared against a batch-level behavioural model.
module tb_fifo_writer_row;

   localparam int BATCH = 9;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_data = '0;
   logic       o_ready;
   logic       o_fifo_wr_en;
   logic [7:0] o_fifo_wr_data;
   logic       i_fifo_full = 1'b0;
   logic       i_fifo_rd_en = 1'b0;
   logic [8:0] o_occupants;
   logic       o_fifo_empty;
   logic       o_batch_done;
   logic       o_underflow;

   fifo_writer_row #(.ROW(9), .COL(1), .W_ADDR(8), .W_DATA(8)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .i_data        (i_data),
      .o_ready       (o_ready),
      .o_fifo_wr_en  (o_fifo_wr_en),
      .o_fifo_wr_data(o_fifo_wr_data),
      .i_fifo_full   (i_fifo_full),
      .i_fifo_rd_en  (i_fifo_rd_en),
      .o_occupants   (o_occupants),
      .o_fifo_empty  (o_fifo_empty),
      .o_batch_done  (o_batch_done),
      .o_underflow   (o_underflow)
   );

   always #5 i_clk = ~i_clk;

   int nChecks = 0;
   int nErrors = 0;

   // Model: fill window open, words taken this batch, words held, pending write.
   bit         mOpen;
   int         mAccepted;
   int         mOcc;
   bit         mPend;
   logic [7:0] mPendData;
   bit         mDone;
   bit         mUnder;

   bit lastAcc;
   bit combArmed = 1'b0;
   int wrSeen;
   int doneSeen;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mOpen = 0; mAccepted = 0; mOcc = 0; mPend = 0;
      mPendData = '0; mDone = 0; mUnder = 0;
   endtask

   task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d,
                                input logic f, input logic r);
      bit expReady, acc, wrNow, counted;
      int oldOcc;
      i_rst_n = rst; i_valid = v; i_data = d; i_fifo_full = f; i_fifo_rd_en = r;
      #1;
      expReady = mOpen && !f && (mAccepted < BATCH);
      if (combArmed) begin
         checkOutput("ready", 32'(o_ready), 32'(expReady));
         checkOutput("empty", 32'(o_fifo_empty), 32'(mOcc == 0));
      end
      @(posedge i_clk);
      acc = 0;
      if (!rst) modelReset();
      else begin
         oldOcc  = mOcc;
         wrNow   = mPend;
         counted = r && (oldOcc > 0);
         if (r && oldOcc == 0) mUnder = 1;
         if (wrNow && !counted) mOcc++;
         else if (counted && !wrNow) mOcc--;
         acc   = v && expReady;
         mDone = 0;
         mPend = acc;
         if (acc) mPendData = d;
         if (mOpen) begin
            if (acc) begin
               mAccepted++;
               if (mAccepted == BATCH) mOpen = 0;
            end
         end else if (mAccepted == BATCH) begin
            if (oldOcc == 0 && !wrNow) begin
               mDone = 1;
               mAccepted = 0;
            end
         end else if (oldOcc == 0) begin
            mOpen = 1;
         end
      end
      lastAcc = acc;
      #1;
      checkOutput("wr_en", 32'(o_fifo_wr_en), 32'(mPend));
      if (mPend) checkOutput("wr_data", 32'(o_fifo_wr_data), 32'(mPendData));
      checkOutput("occupants", 32'(o_occupants), 32'(mOcc));
      checkOutput("batch_done", 32'(o_batch_done), 32'(mDone));
      checkOutput("underflow", 32'(o_underflow), 32'(mUnder));
      if (o_fifo_wr_en === 1'b1) wrSeen++;
      if (o_batch_done === 1'b1) doneSeen++;
      combArmed = 1'b1;
   endtask

   // Directed mode streams words 1..BATCH with valid held high.
   task automatic runFill(input bit randomMode, input int stallAt, input bit sameCycleTest,
                          input int stopAt);
      logic v, f, r;
      logic [7:0] d;
      int stalls, guard;
      bit sameDone, sameNow;
      v = 0; d = '0; f = 0; r = 0; stalls = 3; guard = 0; sameDone = 0;
      lastAcc = 0;
      while (mAccepted < stopAt && guard < 400) begin
         sameNow = 0;
         if (randomMode) begin
            if (!v || lastAcc) begin
               v = ($urandom_range(0, 1) == 1);
               d = 8'($urandom);
            end
            f = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            v = 1; d = 8'(mAccepted + 1); f = 0; r = 0;
            if (mOpen && mAccepted == stallAt && stalls > 0) begin
               f = 1;
               stalls--;
            end
            if (sameCycleTest && !sameDone && mPend && mOcc == 5) begin
               r = 1;
               sameNow = 1;
            end
         end
         applyStimulus(1, v, d, f, r);
         if (sameNow) begin
            checkOutput("same_cycle_occ", 32'(o_occupants), 32'd5);
            sameDone = 1;
         end
         guard++;
      end
      checkOutput("fill_timeout", 32'(guard < 400), 32'd1);
   endtask

   task automatic runDrain(input bit randomMode);
      int guard;
      bit toggle;
      logic r;
      guard = 0; toggle = 0;
      while (!mDone && guard < 200) begin
         if (randomMode) r = (mOcc > 0) && ($urandom_range(0, 2) != 0);
         else begin
            r = (mOcc > 0) && !toggle;
            toggle = !toggle;
         end
         applyStimulus(1, 0, '0, 0, r);
         guard++;
      end
      checkOutput("drain_timeout", 32'(guard < 200), 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_wr_en"}, 32'(o_fifo_wr_en), 32'd0);
      checkOutput({tag, "_wr_data"}, 32'(o_fifo_wr_data), 32'd0);
      checkOutput({tag, "_occ"}, 32'(o_occupants), 32'd0);
      checkOutput({tag, "_done"}, 32'(o_batch_done), 32'd0);
      checkOutput({tag, "_under"}, 32'(o_underflow), 32'd0);
      checkOutput({tag, "_ready"}, 32'(o_ready), 32'd0);
      checkOutput({tag, "_empty"}, 32'(o_fifo_empty), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      wrSeen = 0; doneSeen = 0;
      applyStimulus(0, 0, '0, 0, 0);
      checkResetState("rst");

      // Continuous fill with words 1..9.
      wrSeen = 0;
      runFill(0, -1, 0, BATCH);
      applyStimulus(1, 0, '0, 0, 0);
      checkOutput("t1_writes", 32'(wrSeen), 32'd9);
      checkOutput("t1_occ", 32'(o_occupants), 32'd9);
      checkOutput("t1_ready", 32'(o_ready), 32'd0);

      // Single-cycle read pulses drain the batch.
      doneSeen = 0;
      runDrain(0);
      checkOutput("t2_occ", 32'(o_occupants), 32'd0);
      checkOutput("t2_done_pulses", 32'(doneSeen), 32'd1);
      applyStimulus(1, 1, 8'd1, 0, 0);
      checkOutput("t2_no_accept_in_idle", 32'(o_fifo_wr_en), 32'd0);

      // Full held for three cycles at the fifth word.
      wrSeen = 0;
      runFill(0, 4, 0, BATCH);
      checkOutput("t3_writes", 32'(wrSeen), 32'd9);
      runDrain(1);

      // Read against an empty FIFO.
      checkOutput("t4_pre_under", 32'(o_underflow), 32'd0);
      applyStimulus(1, 0, '0, 0, 1);
      checkOutput("t4_under", 32'(o_underflow), 32'd1);
      repeat (3) applyStimulus(1, 0, '0, 0, 0);
      checkOutput("t4_sticky", 32'(o_underflow), 32'd1);
      checkOutput("t4_occ", 32'(o_occupants), 32'd0);

      // Simultaneous write and counted read at five occupants.
      runFill(0, -1, 1, BATCH);
      runDrain(0);

      // Reset in the middle of a batch, then a clean batch from scratch.
      runFill(0, -1, 0, 6);
      applyStimulus(0, 1, 8'd7, 0, 0);
      checkResetState("t6");
      wrSeen = 0;
      runFill(0, -1, 0, BATCH);
      checkOutput("t6_writes", 32'(wrSeen), 32'd9);
      runDrain(1);

      repeat (4) begin
         runFill(1, -1, 0, BATCH);
         runDrain(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
